// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes, dmem bus and debug counters for dmem_arbiter.
// slave is the arbiter's view; master is the requester/memory/observer side.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rd,
    output ack0, rdata0, ack1, rdata1,
    output mem_a, mem_wd, mem_we,
    output cnt0, cnt1, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rd,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_a, mem_wd, mem_we,
    input  cnt0, cnt1, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-port dmem: one registered access
// cycle per grant, registered read data with a one-cycle ack, saturating counters.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave arb_io
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;

  logic                win;
  logic [DATA_W-1:0]   result;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // On a tie the port that did not win last time gets the grant.
  assign win    = (arb_io.req0 && arb_io.req1) ? ~last_q : arb_io.req1;
  // Writes echo their own data back as the completion value.
  assign result = we_q ? wdata_q : arb_io.mem_rd;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    unique case (state_q)
      StIdle: begin
        if (arb_io.req0 || arb_io.req1) begin
          owner_d = win;
          last_d  = win;
          addr_d  = win ? arb_io.addr1  : arb_io.addr0;
          wdata_d = win ? arb_io.wdata1 : arb_io.wdata0;
          we_d    = win ? arb_io.we1    : arb_io.we0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StIdle;
        if (owner_q) begin
          ack1_d   = 1'b1;
          rdata1_d = result;
          cnt1_d   = sat_inc(cnt1_q);
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = result;
          cnt0_d   = sat_inc(cnt0_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Write strobe decodes from state so an asynchronous reset kills it at once.
  assign arb_io.mem_we = (state_q == StAccess) && we_q;
  assign arb_io.mem_a  = addr_q;
  assign arb_io.mem_wd = wdata_q;
  assign arb_io.busy   = (state_q == StAccess);
  assign arb_io.ack0   = ack0_q;
  assign arb_io.ack1   = ack1_q;
  assign arb_io.rdata0 = rdata0_q;
  assign arb_io.rdata1 = rdata1_q;
  assign arb_io.cnt0   = cnt0_q;
  assign arb_io.cnt1   = cnt1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer sharing the single-port data memory `dmem` between the CPU load/store port (port 0) and a DMA/debug loader port (port 1).
- Accepts valid-request/ack transactions, runs round-robin arbitration and registers the winning command.
- Drives `dmem` `a`/`wd`/`we` for one access cycle, then returns registered read data with a one-cycle ack.
- Keeps saturating per-port transaction counters for performance debug.

Parameters:
- DATA_W, 32, data word width; must match `dmem` `` `DATA_W ``.
- ADDR_W, 16, word address width; must match the `dmem` `a` port.
- CNT_W, 16, width of each per-port saturating transaction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 (CPU) request; held until ack0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse, one cycle.
- rdata0  output  DATA_W  port 0 read data; valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1: same meanings for port 1 (DMA/debug).
- mem_a  output  ADDR_W  to `dmem` `a`.
- mem_wd  output  DATA_W  to `dmem` `wd`.
- mem_we  output  1  to `dmem` `we`.
- mem_rd  input  DATA_W  from `dmem` `rd`; combinational read of `mem_a`.
- cnt0  output  CNT_W  number of completed port 0 transactions, saturating.
- cnt1  output  CNT_W  number of completed port 1 transactions, saturating.
- busy  output  1  high while the FSM is in ACCESS.

Behaviour:
- FSM has two states: IDLE and ACCESS.
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, last grant pointer = 1 (so port 0 wins the first tie).
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0, cnt0 = cnt1 = 0.
  - Registered command (owner, addr_r, wdata_r, we_r) = 0; busy = 0.
- Reset mid-ACCESS aborts the transaction. mem_we drops immediately because it decodes from state, so no write reaches `dmem`. No ack is issued.
- IDLE, no request: stay in IDLE. mem_we = 0; mem_a and mem_wd hold addr_r and wdata_r.
- IDLE, any request: pick a winner.
  - Only one req high: that port wins.
  - Both high: the port that is not the last-granted one wins.
  - Register owner, addr_r, wdata_r and we_r from the winner, update the last grant pointer, go to ACCESS.
- ACCESS, always exactly one cycle:
  - mem_a = addr_r, mem_wd = wdata_r, mem_we = we_r (combinational from the registers).
  - At the closing edge, `dmem` performs the write if we_r = 1.
  - At the same edge, rdata of the owner is loaded with mem_rd for reads. For writes it is loaded with wdata_r, giving write-through echo.
  - Also at that edge: ack of the owner goes to 1, the owner's counter increments (holds at 2^CNT_W-1 once reached), state returns to IDLE.
- The ack cycle coincides with the next IDLE arbitration cycle.
  - A requester that sees its ack may either drop req, or keep req high with new we/addr/wdata to issue its next transaction.
  - A req sampled in the ack cycle is always treated as a new transaction.
- ack0/ack1 are single-cycle pulses and are never high at the same time.
- rdata0/rdata1 hold their value until the next completion on that port.
- Throughput: one transaction per 2 cycles. Request-to-ack latency is 2 cycles when the bus is uncontended.
- The non-granted port keeps waiting with req held. Round-robin bounds its wait to one transaction of the other port.
- Requester inputs that change while req is high but before the grant are legal. Only the values present in the arbitration cycle are used.
- A requester must not change addr/wdata/we after being granted.
  - The arbiter has already registered the command, so later changes are ignored and harmless.
- No X propagation: mem_we is 0 whenever state is not ACCESS.

Test Plan:
- Reset, then port 0 read with addr0 = 1 and `dmem` image word 1 = 32'h00020003 -> mem_we = 0 throughout; ack0 pulses at cycle 2; rdata0 = 32'h00020003; cnt0 = 1.
- Port 1 write of 32'hDEADBEEF to addr 4, then port 0 read of addr 4 -> exactly one cycle with mem_we = 1 and mem_a = 4; ack1 returns rdata1 = 32'hDEADBEEF; rdata0 = 32'hDEADBEEF; cnt1 = 1, cnt0 = 1.
- req0 and req1 both held high for 8 cycles, reads of addr 2 and addr 3 -> grant order 0,1,0,1; ack0/ack1 alternate every 2 cycles; rdata0 = 32'h01020203, rdata1 = 32'h02040206; never both acks high.
- Port 0 keeps req0 high in its ack cycle with a new addr 5 -> back-to-back transactions; second ack0 two cycles later with rdata0 = 32'h04060506.
- Assert rst_n = 0 during the ACCESS cycle of a port 1 write to addr 0 -> mem_we drops immediately; mem[0] stays 32'h070b0001; no ack1; all outputs are zero after reset.
- Force cnt0 to 16'hFFFE via 2 completions, starting from a preloaded or backdoor value -> cnt0 reaches 16'hFFFF and stays there on further transactions.
